// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the RISC-V run controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_ctrl_pkg;

    localparam int DEF_IMEM_ADDR_WIDTH = 10;
    localparam int DEF_CNT_WIDTH       = 32;

    // Instruction addresses arrive as byte addresses; memory is word-addressed.
    localparam int WORD_OFFSET = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DONE
    } run_state_e;

endpackage

// File: rtl/riscv_run_ctrl_if.sv
// User-port bundle between the AXI4-Lite register block and the run controller.
// Latency: n/a (wires only).
// Backpressure: none; all signals are levels or one-cycle strobes.
// Ports: master = register block / host side, slave = run controller side.
interface riscv_run_ctrl_if #(
    parameter int IMEM_ADDR_WIDTH = riscv_ctrl_pkg::DEF_IMEM_ADDR_WIDTH,
    parameter int CNT_WIDTH       = riscv_ctrl_pkg::DEF_CNT_WIDTH
);
    // register block -> controller
    logic                       w_o_run;
    logic [CNT_WIDTH-1:0]       w_o_num_cycle;
    logic                       w_mem_reset_n;
    logic                       w_instruction_write;
    logic [31:0]                w_slv_reg5;
    logic [31:0]                w_slv_reg6;
    // controller -> register block status
    logic                       w_i_idle;
    logic                       w_i_running;
    logic                       w_i_done;
    // controller -> core / instruction memory
    logic                       imem_we;
    logic [IMEM_ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]                imem_wdata;
    logic                       core_rst;
    logic                       core_en;
    logic [CNT_WIDTH-1:0]       cycle_count;
    logic                       load_err;

    modport master (
        output w_o_run, w_o_num_cycle, w_mem_reset_n, w_instruction_write,
               w_slv_reg5, w_slv_reg6,
        input  w_i_idle, w_i_running, w_i_done, imem_we, imem_addr, imem_wdata,
               core_rst, core_en, cycle_count, load_err
    );

    modport slave (
        input  w_o_run, w_o_num_cycle, w_mem_reset_n, w_instruction_write,
               w_slv_reg5, w_slv_reg6,
        output w_i_idle, w_i_running, w_i_done, imem_we, imem_addr, imem_wdata,
               core_rst, core_en, cycle_count, load_err
    );

endinterface

// File: rtl/riscv_edge_det.sv
// Single-edge detector: one history flop, edge_o = selected transition of sig_i.
// Latency: edge_o is combinational on sig_i against the registered history.
// Backpressure: none.
// Ports: clk, rst (sync, active-high), sig_i level in, edge_o one-cycle pulse.
module riscv_edge_det #(
    parameter logic RESET_VAL   = 1'b0,
    parameter bit   DETECT_RISE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic edge_o
);

    logic hist_q;
    logic hist_d;

    always_comb begin
        hist_d = sig_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= RESET_VAL;
        end else begin
            hist_q <= hist_d;
        end
    end

    // RESET_VAL is chosen so that the idle level of the input never looks
    // like an edge straight out of reset.
    assign edge_o = DETECT_RISE ? (sig_i & ~hist_q) : (~sig_i & hist_q);

endmodule

// File: rtl/riscv_run_ctrl.sv
// Run controller: loads/clears instruction memory and runs the core for a cycle budget.
// Latency: every output is a flop; responses appear the cycle after the sampled input.
// Backpressure: none; strobes outside IDLE are dropped and flagged on load_err.
// Ports: s00_axi_aclk/s00_axi_areset (sync, active-high) plus the slave side of
//        riscv_run_ctrl_if (run/clear/write requests in, imem/core/status out).
module riscv_run_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int IMEM_ADDR_WIDTH = DEF_IMEM_ADDR_WIDTH,
    parameter int CNT_WIDTH       = DEF_CNT_WIDTH
) (
    input  logic             s00_axi_aclk,
    input  logic             s00_axi_areset,
    riscv_run_ctrl_if.slave  bus
);

    localparam logic [IMEM_ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [IMEM_ADDR_WIDTH-1:0] ADDR_ONE  = IMEM_ADDR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]       CNT_ONE   = CNT_WIDTH'(1);

    logic run_rise;
    logic mem_fall;
    logic addr_bad;

    run_state_e                 state_q,  state_d;
    logic [CNT_WIDTH-1:0]       target_q, target_d;
    logic [CNT_WIDTH-1:0]       cnt_q,    cnt_d;
    logic [IMEM_ADDR_WIDTH-1:0] addr_q,   addr_d;
    logic [31:0]                wdata_q,  wdata_d;
    logic                       we_q,     we_d;
    logic                       err_q,    err_d;
    logic                       idle_q,   idle_d;
    logic                       running_q, running_d;
    logic                       done_q,   done_d;
    logic                       core_rst_q, core_rst_d;
    logic                       core_en_q,  core_en_d;

    riscv_edge_det #(.RESET_VAL(1'b0), .DETECT_RISE(1'b1)) u_run_edge (
        .clk    (s00_axi_aclk),
        .rst    (s00_axi_areset),
        .sig_i  (bus.w_o_run),
        .edge_o (run_rise)
    );

    riscv_edge_det #(.RESET_VAL(1'b1), .DETECT_RISE(1'b0)) u_clr_edge (
        .clk    (s00_axi_aclk),
        .rst    (s00_axi_areset),
        .sig_i  (bus.w_mem_reset_n),
        .edge_o (mem_fall)
    );

    // Byte address must be word aligned and fall inside the memory.
    always_comb begin
        addr_bad = (bus.w_slv_reg6[WORD_OFFSET-1:0] != '0) ||
                   ((bus.w_slv_reg6 >> (IMEM_ADDR_WIDTH + WORD_OFFSET)) != 32'd0);
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = 1'b0;
        err_d    = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (mem_fall) begin
                    // A clear wins over a same-cycle run edge; that edge is lost.
                    state_d = ST_CLEAR;
                end else if (run_rise) begin
                    target_d = bus.w_o_num_cycle;
                    cnt_d    = '0;
                    state_d  = (bus.w_o_num_cycle == '0) ? ST_DONE : ST_RUN;
                end
                if (bus.w_instruction_write) begin
                    if (addr_bad) begin
                        err_d = 1'b1;
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = bus.w_slv_reg6[IMEM_ADDR_WIDTH+WORD_OFFSET-1:WORD_OFFSET];
                        wdata_d = bus.w_slv_reg5;
                    end
                end
                // The zero-fill starts at word 0 immediately and would overwrite
                // a same-cycle write anyway, so it takes the write port.
                if (mem_fall) begin
                    we_d    = 1'b1;
                    addr_d  = '0;
                    wdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            ST_CLEAR: begin
                we_d    = 1'b1;
                wdata_d = '0;
                if (addr_q == LAST_ADDR) begin
                    we_d    = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                end
                if (bus.w_instruction_write) begin
                    err_d = 1'b1;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_d == target_q) begin
                    state_d = ST_DONE;
                end
                if (bus.w_instruction_write) begin
                    err_d = 1'b1;
                end
            end
            ST_DONE: begin
                // Level-sensitive exit; a new run needs a fresh rising edge in IDLE.
                if (!bus.w_o_run) begin
                    state_d = ST_IDLE;
                end
                if (bus.w_instruction_write) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status and core controls are decoded from the next state so they
        // line up with state_q on the same edge.
        idle_d     = (state_d == ST_IDLE);
        running_d  = (state_d == ST_RUN);
        done_d     = (state_d == ST_DONE);
        core_en_d  = (state_d == ST_RUN);
        core_rst_d = (state_d == ST_IDLE) || (state_d == ST_CLEAR);
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            state_q    <= ST_IDLE;
            target_q   <= '0;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            idle_q     <= 1'b1;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            core_rst_q <= 1'b1;
            core_en_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            err_q      <= err_d;
            idle_q     <= idle_d;
            running_q  <= running_d;
            done_q     <= done_d;
            core_rst_q <= core_rst_d;
            core_en_q  <= core_en_d;
        end
    end

    assign bus.w_i_idle    = idle_q;
    assign bus.w_i_running = running_q;
    assign bus.w_i_done    = done_q;
    assign bus.imem_we     = we_q;
    assign bus.imem_addr   = addr_q;
    assign bus.imem_wdata  = wdata_q;
    assign bus.core_rst    = core_rst_q;
    assign bus.core_en     = core_en_q;
    assign bus.cycle_count = cnt_q;
    assign bus.load_err    = err_q;

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Scoreboard bench for riscv_run_ctrl: directed scenarios then random operations.
// Latency: n/a.
// Backpressure: n/a.
module tb_riscv_run_ctrl;

    localparam int AW    = 10;
    localparam int CW    = 32;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    riscv_run_ctrl_if #(.IMEM_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

    riscv_run_ctrl #(.IMEM_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .s00_axi_aclk   (clk),
        .s00_axi_areset (rst),
        .bus            (bus)
    );

    typedef struct {
        int unsigned addr;
        logic [31:0] data;
    } wr_t;

    wr_t wq[$];      // expected instruction-memory writes, in order
    int  rq[$];      // expected enabled-cycle count of each run
    int  vectors = 0;
    int  errors  = 0;
    bit  exp_err = 1'b0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    int   en_cnt  = 0;
    int   run_cnt = 0;
    logic done_prev = 1'b0;
    wr_t  mon_e;
    int   mon_n;

    always @(negedge clk) begin
        if (rst) begin
            en_cnt    = 0;
            run_cnt   = 0;
            done_prev = 1'b0;
        end else begin
            if (bus.imem_we) begin
                if (wq.size() == 0) begin
                    check("imem_we_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_e = wq.pop_front();
                    check("imem_addr", 64'(bus.imem_addr), 64'(mon_e.addr));
                    check("imem_wdata", 64'(bus.imem_wdata), 64'(mon_e.data));
                end
            end
            if (bus.core_en) en_cnt++;
            if (bus.w_i_running) run_cnt++;
            if (bus.w_i_done && !done_prev) begin
                if (rq.size() == 0) begin
                    check("done_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_n = rq.pop_front();
                    check("run_core_en_cycles", 64'(en_cnt), 64'(mon_n));
                    check("run_running_cycles", 64'(run_cnt), 64'(mon_n));
                    check("run_cycle_count", 64'(bus.cycle_count), 64'(mon_n));
                end
                en_cnt  = 0;
                run_cnt = 0;
            end
            done_prev = bus.w_i_done;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check_reset_vals(input string tag);
        check({tag, "_idle"},     64'(bus.w_i_idle),    64'd1);
        check({tag, "_running"},  64'(bus.w_i_running), 64'd0);
        check({tag, "_done"},     64'(bus.w_i_done),    64'd0);
        check({tag, "_imem_we"},  64'(bus.imem_we),     64'd0);
        check({tag, "_imem_addr"},64'(bus.imem_addr),   64'd0);
        check({tag, "_imem_wdata"},64'(bus.imem_wdata), 64'd0);
        check({tag, "_core_rst"}, 64'(bus.core_rst),    64'd1);
        check({tag, "_core_en"},  64'(bus.core_en),     64'd0);
        check({tag, "_cycle_count"}, 64'(bus.cycle_count), 64'd0);
        check({tag, "_load_err"}, 64'(bus.load_err),    64'd0);
    endtask

    function automatic bit addr_ok(input logic [31:0] a);
        return (a % 4 == 0) && (a < 4 * DEPTH);
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, DEPTH - 1)) * 4;
        case ($urandom_range(0, 3))
            0: a = a | 32'($urandom_range(1, 3));
            1: a = a | (32'd1 << $urandom_range(12, 31));
            default: ;
        endcase
        return a;
    endfunction

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        bus.w_slv_reg5 = d;
        bus.w_slv_reg6 = a;
        bus.w_instruction_write = 1'b1;
        if (addr_ok(a)) wq.push_back('{addr: a / 4, data: d});
        else exp_err = 1'b1;
        tick();
        bus.w_instruction_write = 1'b0;
        check("load_err_after_write", 64'(bus.load_err), 64'(exp_err));
        tick();
    endtask

    task automatic do_run(input int n, input bit wr_same, input bit stray, input int hold);
        int waited;
        logic [31:0] a;
        rq.push_back(n);
        bus.w_o_num_cycle = CW'(n);
        bus.w_o_run = 1'b1;
        if (wr_same) begin
            a = 32'($urandom_range(0, DEPTH - 1)) * 4;
            bus.w_slv_reg6 = a;
            bus.w_slv_reg5 = $urandom;
            bus.w_instruction_write = 1'b1;
            wq.push_back('{addr: a / 4, data: bus.w_slv_reg5});
        end
        tick();
        bus.w_instruction_write = 1'b0;
        if (n == 0) begin
            check("zero_target_done", 64'(bus.w_i_done), 64'd1);
            check("zero_target_core_en", 64'(bus.core_en), 64'd0);
        end else begin
            check("run_entry_running", 64'(bus.w_i_running), 64'd1);
            check("run_core_rst_low", 64'(bus.core_rst), 64'd0);
        end
        if (wr_same) check("write_on_run_entry", 64'(bus.imem_we), 64'd1);
        if (stray) begin
            bus.w_slv_reg6 = 32'h0;
            bus.w_instruction_write = 1'b1;
            exp_err = 1'b1;
            tick();
            bus.w_instruction_write = 1'b0;
            check("strobe_while_busy_no_we", 64'(bus.imem_we), 64'd0);
        end
        waited = 0;
        while (!bus.w_i_done && waited < n + 4) begin
            tick();
            waited++;
        end
        check("run_reaches_done", 64'(bus.w_i_done), 64'd1);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("done_held_run_high", 64'(bus.w_i_done), 64'd1);
            check("done_core_en_low", 64'(bus.core_en), 64'd0);
            check("done_core_rst_low", 64'(bus.core_rst), 64'd0);
        end
        bus.w_o_run = 1'b0;
        tick();
        check("idle_after_run_drop", 64'(bus.w_i_idle), 64'd1);
        check("load_err_after_run", 64'(bus.load_err), 64'(exp_err));
    endtask

    task automatic do_clear(input bit run_pulse, input bit strobe);
        int cycles;
        for (int i = 0; i < DEPTH; i++) wq.push_back('{addr: i, data: 32'h0});
        exp_err = 1'b0;
        bus.w_mem_reset_n = 1'b0;
        tick();
        bus.w_mem_reset_n = 1'b1;
        check("clear_entry_not_idle", 64'(bus.w_i_idle), 64'd0);
        check("clear_load_err_cleared", 64'(bus.load_err), 64'd0);
        cycles = 0;
        while (!bus.w_i_idle && cycles < DEPTH + 50) begin
            bus.w_o_run = run_pulse && (cycles == 100);
            if (strobe && cycles == 300) begin
                bus.w_slv_reg6 = 32'h10;
                bus.w_instruction_write = 1'b1;
                exp_err = 1'b1;
            end else begin
                bus.w_instruction_write = 1'b0;
            end
            tick();
            cycles++;
        end
        bus.w_instruction_write = 1'b0;
        bus.w_o_run = 1'b0;
        check("clear_cycles", 64'(cycles), 64'(DEPTH));
        check("clear_queue_drained", 64'(wq.size()), 64'd0);
        check("load_err_after_clear", 64'(bus.load_err), 64'(exp_err));
        tick();
        check("idle_after_clear", 64'(bus.w_i_idle), 64'd1);
        check("no_run_after_clear", 64'(bus.w_i_running), 64'd0);
    endtask

    task automatic do_reset_midrun();
        rq.push_back(10);
        bus.w_o_num_cycle = CW'(10);
        bus.w_o_run = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b1;
        bus.w_o_run = 1'b0;
        rq.delete();
        tick();
        check_reset_vals("midrun_reset");
        rst = 1'b0;
        exp_err = 1'b0;
        tick();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bus.w_o_run             = 1'b0;
        bus.w_o_num_cycle       = '0;
        bus.w_mem_reset_n       = 1'b1;
        bus.w_instruction_write = 1'b0;
        bus.w_slv_reg5          = '0;
        bus.w_slv_reg6          = '0;
        tick();
        tick();
        check_reset_vals("reset");
        rst = 1'b0;
        tick();

        do_write(32'h0, 32'h0000_0013);
        do_write(32'h4, 32'h0010_0093);
        do_write(32'h8, 32'h0020_8113);
        do_run(5, 1'b0, 1'b0, 0);

        do_write(32'h6, 32'hdead_beef);
        do_write(32'h1000, 32'hcafe_f00d);
        do_run(7, 1'b0, 1'b1, 2);

        do_clear(1'b1, 1'b0);
        do_run(0, 1'b0, 1'b0, 1);
        do_reset_midrun();
        do_run(3, 1'b1, 1'b0, 0);
        do_run(1, 1'b0, 1'b0, 0);

        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: do_write(rand_addr(), $urandom);
                5, 6, 7, 8: do_run($urandom_range(0, 30), 1'($urandom_range(0, 1)),
                                   1'($urandom_range(0, 1)), $urandom_range(0, 3));
                default: do_clear(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            endcase
        end

        tick();
        check("final_write_queue_empty", 64'(wq.size()), 64'd0);
        check("final_run_queue_empty", 64'(rq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
